// File: rtl/dds_mod_ctrl_pkg.sv
// Shared constants and types for the DDS symbol sequencer.
package dds_mod_pkg;

    localparam int DDS_PHASE_W = 8;

    localparam logic [1:0] MODE_CW   = 2'b00;
    localparam logic [1:0] MODE_ASK  = 2'b01;
    localparam logic [1:0] MODE_FSK  = 2'b10;
    localparam logic [1:0] MODE_BPSK = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BIT = 2'd1,
        SEND     = 2'd2,
        CW       = 2'd3
    } state_t;

    // Half-cycle phase offset at the default phase width.
    localparam logic [DDS_PHASE_W-1:0] PSK_OFS = DDS_PHASE_W'(1) << (DDS_PHASE_W - 1);

endpackage

// File: rtl/dds_mod_ctrl_if.sv
// Serial bit-stream port between the bit source and the symbol sequencer.
// A bit moves when bit_valid & bit_ready at a rising edge; bit_data is only sampled
// then, and bit_ready never looks at bit_valid.
interface dds_mod_ctrl_if;
    logic bit_valid;
    logic bit_data;
    logic bit_ready;

    modport master (output bit_valid, output bit_data, input bit_ready);
    modport slave  (input bit_valid, input bit_data, output bit_ready);
endinterface

// File: rtl/dds_mod_ctrl_sym_counter.sv
// Sample-within-symbol down-counter: clear beats load beats decrement; it stops at zero.
module sym_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dds_mod_ctrl.sv
// Symbol sequencer: turns a serial bit stream into registered DDS step/offset/gate
// controls for CW, ASK, FSK and BPSK, holding each bit for SAMPLES_PER_SYM cycles.
module dds_mod_ctrl
    import dds_mod_pkg::*;
#(
    parameter int PHASE_W         = DDS_PHASE_W,
    parameter int SAMPLES_PER_SYM = 16,
    parameter int CNT_W           = $clog2(SAMPLES_PER_SYM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_step0,
    input  logic [PHASE_W-1:0] cfg_step1,
    dds_mod_ctrl_if.slave      bit_if,
    output logic               dds_en,
    output logic [PHASE_W-1:0] dds_step,
    output logic [PHASE_W-1:0] dds_phase_ofs,
    output logic               amp_en,
    output logic               sym_strobe,
    output logic               busy,
    output logic               underrun,
    output state_t             dbg_state
);

    localparam logic [PHASE_W-1:0] HALF_OFS = PHASE_W'(1) << (PHASE_W - 1);
    localparam logic [CNT_W-1:0]   SYM_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

    state_t             state, state_d;
    logic [1:0]         mode_q;
    logic [PHASE_W-1:0] step0_q, step1_q;
    logic               go, xfer;
    logic               cnt_tc, cnt_load, cnt_clr;
    logic [PHASE_W-1:0] sym_step, sym_ofs, step_d, ofs_d;
    logic               sym_amp, en_d, amp_d, strobe_d, underrun_d;

    assign go        = start & ~stop;
    assign bit_if.bit_ready = ~stop & ((state == WAIT_BIT) | ((state == SEND) & cnt_tc));
    assign xfer      = bit_if.bit_valid & bit_if.bit_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    sym_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .en       (state == SEND),
        .load_val (SYM_LAST),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Configuration is frozen for the whole session; only an accepted start reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_CW;
            step0_q <= '0;
            step1_q <= '0;
        end else if ((state == IDLE) && go) begin
            mode_q  <= cfg_mode;
            step0_q <= cfg_step0;
            step1_q <= cfg_step1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (go) state_d = (cfg_mode == MODE_CW) ? CW : WAIT_BIT;
            CW:       if (stop) state_d = IDLE;
            WAIT_BIT: begin
                if (stop)      state_d = IDLE;
                else if (xfer) state_d = SEND;
            end
            SEND: begin
                if (stop)                 state_d = IDLE;
                else if (cnt_tc && !xfer) state_d = WAIT_BIT;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sym_step = step0_q;
        sym_ofs  = '0;
        sym_amp  = 1'b1;
        case (mode_q)
            MODE_ASK:  sym_amp = bit_if.bit_data;
            MODE_FSK:  if (bit_if.bit_data) sym_step = step1_q;
            MODE_BPSK: if (bit_if.bit_data) sym_ofs = HALF_OFS;
            default:   ;
        endcase
    end

    // Next values of the registered outputs; stop truncates whatever is in flight.
    always_comb begin
        en_d       = dds_en;
        amp_d      = amp_en;
        step_d     = dds_step;
        ofs_d      = dds_phase_ofs;
        strobe_d   = 1'b0;
        underrun_d = underrun;
        cnt_load   = 1'b0;
        cnt_clr    = 1'b0;
        if ((state == IDLE) || stop) begin
            en_d    = 1'b0;
            amp_d   = 1'b0;
            step_d  = '0;
            ofs_d   = '0;
            cnt_clr = 1'b1;
            if ((state == IDLE) && go) begin
                underrun_d = 1'b0;
                if (cfg_mode == MODE_CW) begin
                    en_d   = 1'b1;
                    amp_d  = 1'b1;
                    step_d = cfg_step0;
                end
            end
        end else if ((state == WAIT_BIT) || (state == SEND)) begin
            if (xfer) begin
                en_d     = 1'b1;
                amp_d    = sym_amp;
                step_d   = sym_step;
                ofs_d    = sym_ofs;
                strobe_d = 1'b1;
                cnt_load = 1'b1;
            end else if ((state == SEND) && cnt_tc) begin
                underrun_d = 1'b1;
                en_d       = 1'b0;
                amp_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dds_en        <= 1'b0;
            dds_step      <= '0;
            dds_phase_ofs <= '0;
            amp_en        <= 1'b0;
            sym_strobe    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            dds_en        <= en_d;
            dds_step      <= step_d;
            dds_phase_ofs <= ofs_d;
            amp_en        <= amp_d;
            sym_strobe    <= strobe_d;
            underrun      <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dds_mod_ctrl.sv
// Randomised and directed checks of dds_mod_ctrl against a symbol-level reference model.
module tb_dds_mod_ctrl;
    import dds_mod_pkg::*;

    localparam int PHASE_W = 8;
    localparam int SPS     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, stop;
    logic [1:0]         cfg_mode;
    logic [PHASE_W-1:0] cfg_step0, cfg_step1;
    logic               dds_en, amp_en, sym_strobe, busy, underrun;
    logic [PHASE_W-1:0] dds_step, dds_phase_ofs;
    state_t             dbg_state;

    dds_mod_ctrl_if bif();

    dds_mod_ctrl #(.PHASE_W(PHASE_W), .SAMPLES_PER_SYM(SPS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .cfg_mode      (cfg_mode),
        .cfg_step0     (cfg_step0),
        .cfg_step1     (cfg_step1),
        .bit_if        (bif),
        .dds_en        (dds_en),
        .dds_step      (dds_step),
        .dds_phase_ofs (dds_phase_ofs),
        .amp_en        (amp_en),
        .sym_strobe    (sym_strobe),
        .busy          (busy),
        .underrun      (underrun),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: session flags plus samples left in the current symbol
    int                 n_checks = 0;
    int                 n_errors = 0;
    bit                 m_busy, m_cw, m_en, m_amp, m_strobe, m_under, m_acc;
    int                 m_left;
    logic [PHASE_W-1:0] m_step, m_ofs, m_s0, m_s1;
    logic [1:0]         m_mode;
    logic [2*PHASE_W:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cw = 0; m_en = 0; m_amp = 0; m_strobe = 0; m_under = 0; m_acc = 0;
        m_left = 0; m_step = '0; m_ofs = '0; m_s0 = '0; m_s1 = '0; m_mode = 2'b00;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit rdy);
        logic [PHASE_W-1:0] st, of;
        bit                 am, b;
        m_acc    = 0;
        m_strobe = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_mode = cfg_mode; m_s0 = cfg_step0; m_s1 = cfg_step1;
                m_under = 0; m_busy = 1; m_left = 0;
                m_cw = (cfg_mode == 2'd0);
                if (m_cw) begin
                    m_en = 1; m_amp = 1; m_step = cfg_step0; m_ofs = '0;
                end
            end
        end else if (stop) begin
            m_busy = 0; m_cw = 0; m_left = 0;
            m_en = 0; m_amp = 0; m_step = '0; m_ofs = '0;
        end else if (!m_cw) begin
            if (rdy && bif.bit_valid) begin
                b  = bif.bit_data;
                st = m_s0; of = '0; am = 1;
                if (m_mode == 2'd1) am = b;
                if (m_mode == 2'd2 && b) st = m_s1;
                if (m_mode == 2'd3 && b) of = PHASE_W'(1 << (PHASE_W - 1));
                m_step = st; m_ofs = of; m_amp = am; m_en = 1;
                m_strobe = 1; m_acc = 1; m_left = SPS;
                exp_q.push_back({am, of, st});
            end else if (m_left == 1) begin
                m_under = 1; m_en = 0; m_amp = 0; m_left = 0;
            end else if (m_left > 1) begin
                m_left--;
            end
        end
    endtask

    // one clock: compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        bit                 rdy;
        logic [2*PHASE_W:0] e;
        @(negedge clk);
        check_eq("dds_en", dds_en, m_en);
        check_eq("dds_step", dds_step, m_step);
        check_eq("dds_phase_ofs", dds_phase_ofs, m_ofs);
        check_eq("amp_en", amp_en, m_amp);
        check_eq("sym_strobe", sym_strobe, m_strobe);
        check_eq("busy", busy, m_busy);
        check_eq("underrun", underrun, m_under);
        rdy = m_busy && !m_cw && !stop && (m_left <= 1);
        check_eq("bit_ready", bif.bit_ready, rdy);
        if (sym_strobe) begin
            check_eq("strobe_has_symbol", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("symbol_outputs", {amp_en, dds_phase_ofs, dds_step}, e);
            end
        end
        @(posedge clk);
        model_edge(rdy);
        #1;
    endtask

    // driver tasks
    task automatic start_session(input logic [1:0] mode, input logic [PHASE_W-1:0] s0, s1);
        cfg_mode = mode; cfg_step0 = s0; cfg_step1 = s1; start = 1;
        cycle();
        start = 0;
    endtask

    task automatic stop_session();
        stop = 1;
        cycle();
        stop = 0;
        cycle();
    endtask

    task automatic send_bits(input logic [7:0] pat, input int n);
        int i = 0;
        int guard = 0;
        bif.bit_valid = 1;
        while (i < n && guard < n * SPS * 2 + 10) begin
            bif.bit_data = pat[i];
            cycle();
            if (m_acc) i++;
            guard++;
        end
        check_eq("send_bits_done", i, n);
        bif.bit_valid = 0;
    endtask

    task automatic run_until_left(input int left);
        int guard = 0;
        while (m_left != left && guard < 4 * SPS) begin
            cycle();
            guard++;
        end
        check_eq("reach_symbol_point", m_left, left);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check_eq("rst_dds_en", dds_en, 0);
        check_eq("rst_dds_step", dds_step, 0);
        check_eq("rst_dds_phase_ofs", dds_phase_ofs, 0);
        check_eq("rst_amp_en", amp_en, 0);
        check_eq("rst_sym_strobe", sym_strobe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_bit_ready", bif.bit_ready, 0);
        check_eq("rst_state", dbg_state, IDLE);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; cfg_mode = 2'b00; cfg_step0 = '0; cfg_step1 = '0;
        bif.bit_valid = 0; bif.bit_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (3) cycle();

        // reset in the middle of an FSK symbol with the counter at 7
        start_session(MODE_FSK, 8'd8, 8'd16);
        bif.bit_valid = 1; bif.bit_data = 1;
        cycle();
        run_until_left(8);
        async_reset_check();
        bif.bit_valid = 0;
        repeat (2) cycle();

        // FSK 1,0,1 back to back, then underrun
        start_session(MODE_FSK, 8'd8, 8'd16);
        send_bits(8'b101, 3);
        repeat (SPS + 4) cycle();
        stop_session();

        // BPSK 0,1
        start_session(MODE_BPSK, 8'd5, 8'd99);
        send_bits(8'b10, 2);
        repeat (SPS + 2) cycle();
        stop_session();

        // ASK underrun, restart from WAIT_BIT, underrun held until next start
        start_session(MODE_ASK, 8'd7, 8'd0);
        send_bits(8'b1, 1);
        repeat (SPS + 5) cycle();
        send_bits(8'b1, 1);
        repeat (5) cycle();
        stop_session();
        repeat (2) cycle();
        start_session(MODE_ASK, 8'd7, 8'd0);
        stop_session();

        // CW for 50 cycles with bits offered
        start_session(MODE_CW, 8'd4, 8'd0);
        for (int i = 0; i < 50; i++) begin
            bif.bit_valid = ($urandom_range(0, 1) == 1);
            bif.bit_data  = $urandom_range(0, 1);
            cycle();
        end
        bif.bit_valid = 0;
        stop_session();

        // stop together with an offered bit at the symbol boundary
        start_session(MODE_BPSK, 8'd3, 8'd0);
        send_bits(8'b1, 1);
        bif.bit_valid = 1; bif.bit_data = 0;
        run_until_left(1);
        stop = 1;
        cycle();
        stop = 0;
        bif.bit_valid = 0;
        repeat (2) cycle();

        // start and stop together while idle
        start = 1; stop = 1; cfg_mode = MODE_FSK;
        cycle();
        start = 0; stop = 0;
        repeat (2) cycle();

        // randomised sessions, including config churn, stray starts and early stops
        for (int s = 0; s < 12; s++) begin
            int n;
            start_session(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            n = $urandom_range(60, 250);
            for (int c = 0; c < n; c++) begin
                bif.bit_valid = ($urandom_range(0, 9) != 0);
                bif.bit_data  = $urandom_range(0, 1);
                cfg_mode      = 2'($urandom_range(0, 3));
                cfg_step0     = 8'($urandom_range(0, 255));
                cfg_step1     = 8'($urandom_range(0, 255));
                start         = ($urandom_range(0, 19) == 0);
                stop          = ($urandom_range(0, 199) == 0);
                cycle();
            end
            start = 0; stop = 0; bif.bit_valid = 0;
            stop_session();
        end

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dds_mod_ctrl.md
Name: dds_mod_ctrl

Overview:
- Symbol sequencer for the DDS datapath (phase accumulator + quarter-wave ROM + two's-complement output stage).
- Accepts a serial bit stream over a valid/ready handshake and holds each bit for SAMPLES_PER_SYM clock cycles.
- Drives the DDS phase increment, phase offset, amplitude gate and enable to produce CW, ASK, FSK or BPSK.
- Sits between the bit source and DDS_Data_Path.

Parameters:
PHASE_W, 8, phase word width; the MSB of the offset is the half-cycle bit
SAMPLES_PER_SYM, 16, clock cycles per symbol; must be >= 2
CNT_W, $clog2(SAMPLES_PER_SYM), width of the symbol sample counter (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches config and begins transmission
stop  in  1  level; returns the block to IDLE
cfg_mode  in  2  00 CW, 01 ASK, 10 FSK, 11 BPSK
cfg_step0  in  PHASE_W  phase increment for bit 0, and for CW/ASK/BPSK
cfg_step1  in  PHASE_W  phase increment for bit 1 (FSK only)
bit_valid  in  1  source has a bit
bit_data  in  1  bit value
bit_ready  out  1  controller accepts a bit this cycle
dds_en  out  1  phase accumulator advance enable
dds_step  out  PHASE_W  phase increment to the accumulator
dds_phase_ofs  out  PHASE_W  phase offset added before ROM addressing
amp_en  out  1  0 forces DDS output to zero (ASK off)
sym_strobe  out  1  one-cycle pulse on the first sample of each symbol
busy  out  1  state != IDLE
underrun  out  1  sticky; no bit was available at a symbol boundary

Behaviour:
- Reset (async, any time, including mid-symbol) puts the FSM in IDLE. All outputs go to 0, including underrun. The counter clears.
- All outputs are registered. A bit accepted at edge k appears on dds_step, dds_phase_ofs and amp_en from cycle k+1. It holds for exactly SAMPLES_PER_SYM cycles.
- Handshake: a transfer occurs when bit_valid & bit_ready at a rising edge. bit_data is sampled only on a transfer. bit_ready never depends combinationally on bit_valid.
- The state encoding is IDLE, WAIT_BIT, SEND, CW.
- IDLE:
  - bit_ready=0, dds_en=0.
  - start latches cfg_mode, cfg_step0 and cfg_step1 into internal registers and clears underrun.
  - Next state is CW if mode=00, else WAIT_BIT.
  - cfg_* changes while busy have no effect.
- CW:
  - dds_en=1, dds_step=step0, ofs=0, amp_en=1, bit_ready=0.
  - No bits are consumed. The block stays in CW until stop.
- WAIT_BIT:
  - bit_ready=1, dds_en=0, amp_en=0.
  - On a transfer, load the counter with SAMPLES_PER_SYM-1, apply the symbol outputs, pulse sym_strobe, and go to SEND.
- SEND:
  - dds_en=1. The counter decrements every cycle.
  - bit_ready=1 only when counter==0, which allows back-to-back symbols with no gap.
  - Counter==0 with a transfer: reload the counter, apply the new bit, pulse sym_strobe, and stay in SEND.
  - Counter==0 with no transfer: set underrun, go to WAIT_BIT, and drop dds_en and amp_en. The phase accumulator freezes and does not reset.
- Symbol mapping for captured bit b:
  - ASK: step=step0, ofs=0, amp_en=b.
  - FSK: step = b ? step1 : step0, ofs=0, amp_en=1.
  - BPSK: step=step0, ofs = b ? (1<<(PHASE_W-1)) : 0, amp_en=1.
- stop:
  - From any non-IDLE state, go to IDLE at the next edge.
  - stop has priority over start and over transfers; bit_ready is forced to 0 while stop=1.
  - The symbol in progress is truncated.
  - underrun is retained until the next start.
- start while busy is ignored.
- start and stop high in the same cycle while in IDLE: remain in IDLE.
- Counter wrap: the counter never decrements below 0. It is only reloaded or left idle.
- The same bit repeated across consecutive symbols gives continuous, glitch-free outputs; sym_strobe still pulses.

Decomposition:
- Package dds_mod_pkg contains:
  - mode encoding constants: MODE_CW, MODE_ASK, MODE_FSK, MODE_BPSK;
  - the FSM state enum;
  - PSK_OFS = 1<<(PHASE_W-1);
  - the default PHASE_W.
- One sub-module, sym_counter: a parameterised down-counter with load, enable and terminal-count (tc) output. It is instantiated once.

Test Plan:
1. Reset mid-SEND (FSK, counter=7) -> all outputs 0 on the same cycle, FSM in IDLE, underrun=0.
2. FSK, step0=8, step1=16, source always valid with bits 1,0,1 -> dds_step 16,8,16, each for exactly 16 cycles, no gap; sym_strobe 3 pulses 16 cycles apart; bit_ready high only on the cycles where counter==0.
3. BPSK, bits 0,1 -> dds_phase_ofs 0 for 16 cycles, then 128 for 16 cycles; dds_step=step0 throughout.
4. ASK with bit_valid dropped after the first bit -> underrun=1 at the boundary; dds_en and amp_en go to 0; the next valid bit restarts SEND; underrun stays 1 until the next start.
5. CW, step0=4, run 50 cycles, then stop=1 -> dds_en=1 and bit_ready=0 for the whole run; IDLE on the following cycle; busy=0.
6. In SEND, stop=1 and a transfer in the same cycle at counter==0 -> bit not accepted (bit_ready=0); IDLE next cycle.
